display_buffer_reader: RTL and testbench



---
 rtl/display_buffer_reader.sv | 129 ++++++++++++
 tb/tb_display_buffer_reader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/display_buffer_reader.sv
// Avalon-MM read master: fetches one frame from the selected display-buffer bank
// and streams it through a first-word-fall-through FIFO to the LED scan logic.
module display_buffer_reader #(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              NUM_WORDS  = 512,
  parameter int              FIFO_DEPTH = 16,
  parameter logic [ADDR_W-1:0] BANK0_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] BANK1_BASE = 32'h0000_0800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        ctrl,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  input  logic              readdatavalid,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eof,
  output logic              busy,
  output logic              frame_done
);

  localparam int BYTES = DATA_W / 8;
  localparam int CW    = $clog2(NUM_WORDS + 1);
  localparam int PW    = $clog2(FIFO_DEPTH + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [CW-1:0]     issued_q, received_q;
  logic [PW-1:0]     pending_q, pending_d;
  logic [PW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_q, rd_q;
  logic              frame_done_q;
  logic [DATA_W+1:0] mem_q [FIFO_DEPTH];

  logic              accept, push, pop;
  logic [PW:0]       inflight;
  logic [DATA_W+1:0] head;
  logic              unused_ctrl;

  assign unused_ctrl = ^ctrl[7:2];

  // Reads already accepted still need FIFO room, so they count against the depth.
  assign inflight = {1'b0, pending_q} + {1'b0, count_q};
  assign read     = (state_q == READ) && (issued_q < CW'(NUM_WORDS))
                    && (inflight < (PW+1)'(FIFO_DEPTH));
  assign address  = read ? base_q + ADDR_W'(issued_q) * ADDR_W'(BYTES) : '0;
  assign accept   = read && !waitrequest;
  // Data arriving with nothing outstanding is left over from before a reset.
  assign push     = readdatavalid && (pending_q != '0);
  assign pop      = pix_valid && pix_ready;

  always_comb begin
    pending_d = pending_q;
    if (accept && !push)      pending_d = pending_q + 1'b1;
    else if (!accept && push) pending_d = pending_q - 1'b1;
    count_d = count_q;
    if (push && !pop)         count_d = count_q + 1'b1;
    else if (!push && pop)    count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      issued_q     <= '0;
      received_q   <= '0;
      pending_q    <= '0;
      count_q      <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      count_q      <= count_d;
      frame_done_q <= 1'b0;
      if (push) begin
        wr_q       <= wr_q + 1'b1;
        received_q <= received_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (ctrl[0]) begin
            base_q     <= ctrl[1] ? BANK1_BASE : BANK0_BASE;
            issued_q   <= '0;
            received_q <= '0;
            state_q    <= READ;
          end
        end
        READ: begin
          if (accept) begin
            issued_q <= issued_q + 1'b1;
            if (issued_q == CW'(NUM_WORDS - 1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (push && received_q == CW'(NUM_WORDS - 1)) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= {readdata, received_q == '0, received_q == CW'(NUM_WORDS - 1)};
  end

  assign head       = mem_q[rd_q];
  assign pix_valid  = (count_q != '0);
  assign pix_data   = pix_valid ? head[DATA_W+1:2] : '0;
  assign pix_sof    = pix_valid & head[1];
  assign pix_eof    = pix_valid & head[0];
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_buffer_reader.sv
// Randomized bench: Avalon slave with programmable latency/stall plus a frame-level
// reference model (expected addresses, words, sof/eof, busy, frame_done).
module tb_display_buffer_reader;

  localparam int NW    = 8;
  localparam int DEPTH = 4;
  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] B1 = 32'h0000_0800;

  logic        clk, reset, read, waitrequest, readdatavalid;
  logic        pix_valid, pix_ready, pix_sof, pix_eof, busy, frame_done;
  logic [7:0]  ctrl;
  logic [31:0] address, readdata, pix_data;

  display_buffer_reader #(
    .ADDR_W(32), .DATA_W(32), .NUM_WORDS(NW), .FIFO_DEPTH(DEPTH),
    .BANK0_BASE(B0), .BANK1_BASE(B1)
  ) dut (
    .clk(clk), .reset(reset), .ctrl(ctrl), .address(address), .read(read),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eof(pix_eof), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit live; } req_t;
  typedef struct { logic [31:0] d; bit sof; bit eof; } word_t;

  req_t        sq[$];
  word_t       sb[$];
  int          n_checks = 0, n_errors = 0;
  int          cyc = 0, k = 0, rcv = 0, outstanding = 0, acc = 0, stale = 0;
  int          frames_obs = 0, frames_model = 0;
  bit          active = 0, exp_done = 0, was_rst = 1;
  logic [31:0] base = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit rst, input logic [7:0] c, input int wpct, input int rpct,
                      input int lat);
    bit    fin;
    req_t  r;
    word_t e;
    @(negedge clk);
    cyc++;
    check("busy", busy, active);
    check("frame_done", frame_done, exp_done);
    if (frame_done) frames_obs++;
    check("pix_valid", pix_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      check("pix_data", pix_data, sb[0].d);
      check("pix_sof", pix_sof, sb[0].sof);
      check("pix_eof", pix_eof, sb[0].eof);
    end
    check("read", read, active && k < NW && (outstanding + sb.size()) < DEPTH);
    if (read) check("address", address, base + 32'(4 * k));
    check("fifo_bound", sb.size() <= DEPTH, 1'b1);
    if (was_rst) begin
      check("rst_address", address, 0);
      check("rst_pix_data", pix_data, 0);
      check("rst_sof_eof", {pix_sof, pix_eof}, 0);
    end

    reset         = rst;
    ctrl          = c;
    waitrequest   = ($urandom_range(99) < wpct);
    pix_ready     = ($urandom_range(99) < rpct);
    readdatavalid = 1'b0;
    was_rst       = rst;
    exp_done      = 0;
    fin           = 0;
    if (!rst) begin
      if (pix_valid && pix_ready && sb.size() != 0) void'(sb.pop_front());
      if (read && !waitrequest) begin
        r.addr = address; r.due = cyc + lat; r.live = 1;
        sq.push_back(r);
        k++; outstanding++; acc++;
      end
    end
    if (sq.size() != 0 && sq[0].due <= cyc) begin
      r = sq.pop_front();
      readdatavalid = 1'b1;
      readdata      = memf(r.addr);
      if (!rst && r.live) begin
        outstanding--;
        e.d = memf(base + 32'(4 * rcv)); e.sof = (rcv == 0); e.eof = (rcv == NW - 1);
        sb.push_back(e);
        if (rcv == NW - 1) fin = 1;
        rcv++;
      end else stale++;
    end
    if (rst) begin
      active = 0; k = 0; outstanding = 0;
      sb.delete();
      foreach (sq[i]) sq[i].live = 0;
    end else if (!active && c[0]) begin
      active = 1; base = c[1] ? B1 : B0; k = 0; rcv = 0;
    end else if (fin) begin
      active = 0; exp_done = 1; frames_model++;
    end
  endtask

  initial begin
    reset = 1'b1; ctrl = '0; waitrequest = 1'b0; readdata = '0;
    readdatavalid = 1'b0; pix_ready = 1'b0;
    repeat (3) step(1, 8'h00, 0, 100, 2);

    // single frame, zero-wait slave, latency 2
    step(0, 8'h01, 0, 100, 2);
    repeat (30) step(0, 8'h00, 0, 100, 2);
    check("p1_frames", frames_obs, 1);

    // bank 1 held, then switched to bank 0 mid-frame
    repeat (10) step(0, 8'h03, 0, 100, 2);
    repeat (25) step(0, 8'h01, 0, 100, 2);
    repeat (30) step(0, 8'h00, 0, 100, 2);
    check("p2_frames", frames_obs, frames_model);

    // 50% waitrequest
    repeat (80) step(0, 8'h01, 50, 100, 3);
    repeat (40) step(0, 8'h00, 50, 100, 3);
    check("p3_frames", frames_obs, frames_model);

    // consumer stalled: throttle must stop at FIFO depth
    acc = 0;
    step(0, 8'h01, 0, 0, 2);
    repeat (20) step(0, 8'h00, 0, 0, 2);
    check("p4_accepts", acc, DEPTH);
    repeat (30) step(0, 8'h00, 0, 100, 2);
    check("p4_frames", frames_obs, frames_model);

    // reset with three reads outstanding, then stale responses
    acc = 0;
    step(0, 8'h01, 0, 100, 6);
    for (int i = 0; i < 20 && acc < 3; i++) step(0, 8'h00, 0, 100, 6);
    check("p5_reach_3_pending", acc, 3);
    repeat (2) step(1, 8'h00, 0, 100, 6);
    for (int i = 0; i < 30 && sq.size() != 0; i++) step(0, 8'h00, 0, 100, 6);
    check("p5_stale_drain_timeout", sq.size(), 0);
    repeat (3) step(0, 8'h00, 0, 100, 6);

    // long latency, random stalls on both sides, back-to-back frames
    repeat (100) step(0, 8'h01, 30, 70, 6);
    repeat (80) step(0, 8'h00, 30, 70, 6);
    check("p6_frames", frames_obs, frames_model);
    check("p6_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
